sr_drive_ctrl: RTL and testbench

SR_DRIVE_CTRL -- requirements
Module: sr_drive_ctrl

---
 rtl/sr_drive_ctrl_pkg.sv | 18 +
 rtl/sr_drive_ctrl_if.sv | 12 +
 rtl/sr_drive_ctrl_debounce.sv | 37 +++
 rtl/sr_drive_ctrl.sv | 97 +++++++++
 tb/tb_sr_drive_ctrl.sv | 210 +++++++++++++++++++++
 5 files changed

// File: rtl/sr_drive_ctrl_pkg.sv
// Shared types and sizing for the SR latch drive controller and its benches.
package sr_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    SET_PULSE = 2'd1,
    RST_PULSE = 2'd2,
    GAP       = 2'd3
  } sr_state_e;

  localparam int PULSE_CNT_W = 4;

  // Debounce counter width: enough bits to hold DEBOUNCE_CYCLES.
  function automatic int dbc_width(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/sr_drive_ctrl_if.sv
// Button inputs and latch drive outputs of the SR drive controller.
interface sr_drive_if;
  logic set_btn;
  logic reset_btn;
  logic s_out;
  logic r_out;
  logic busy;
  logic conflict;

  modport master (output set_btn, reset_btn, input s_out, r_out, busy, conflict);
  modport slave  (input set_btn, reset_btn, output s_out, r_out, busy, conflict);
endinterface

// File: rtl/sr_drive_ctrl_debounce.sv
// Two-flop synchronizer followed by a consecutive-cycle debouncer.
module sr_debounce
  import sr_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic level
);

  localparam int CW = dbc_width(DEBOUNCE_CYCLES);

  logic [1:0]    sync;
  logic [CW-1:0] cnt;

  // Synchronize, then accept a new level only after it has held long enough.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync  <= '0;
      cnt   <= '0;
      level <= 1'b0;
    end else begin
      sync <= {sync[0], raw};
      if (sync[1] == level) begin
        cnt <= '0;
      end else if (cnt >= CW'(DEBOUNCE_CYCLES - 1)) begin
        level <= sync[1];
        cnt   <= '0;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end

endmodule

// File: rtl/sr_drive_ctrl.sv
// Turns debounced set/reset buttons into non-overlapping SR latch pulses.
module sr_drive_ctrl
  import sr_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int PULSE_CYCLES    = 2
) (
  input  logic        clk,
  input  logic        rst,
  sr_drive_if.slave   bus
);

  logic                   lvl_s, lvl_r;
  logic                   lvl_s_q, lvl_r_q;
  logic                   req_s, req_r;
  sr_state_e              state, state_n;
  logic                   pend_s, pend_r, pend_s_n, pend_r_n;
  logic                   conflict_c;
  logic [PULSE_CNT_W-1:0] pcnt;
  logic                   s_q, r_q;

  sr_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_set (
    .clk(clk), .rst(rst), .raw(bus.set_btn), .level(lvl_s)
  );

  sr_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_rst (
    .clk(clk), .rst(rst), .raw(bus.reset_btn), .level(lvl_r)
  );

  // Rising-edge detect on debounced levels gives one-cycle requests.
  always_ff @(posedge clk) begin
    if (rst) begin
      lvl_s_q <= 1'b0;
      lvl_r_q <= 1'b0;
      req_s   <= 1'b0;
      req_r   <= 1'b0;
    end else begin
      lvl_s_q <= lvl_s;
      lvl_r_q <= lvl_r;
      req_s   <= lvl_s & ~lvl_s_q;
      req_r   <= lvl_r & ~lvl_r_q;
    end
  end

  // Next state: IDLE serves fresh or pending requests, busy states queue them.
  always_comb begin
    state_n    = state;
    pend_s_n   = pend_s;
    pend_r_n   = pend_r;
    conflict_c = 1'b0;
    case (state)
      IDLE: begin
        pend_s_n = 1'b0;
        pend_r_n = 1'b0;
        if ((req_s | pend_s) && (req_r | pend_r)) conflict_c = 1'b1;
        else if (req_s | pend_s)                  state_n    = SET_PULSE;
        else if (req_r | pend_r)                  state_n    = RST_PULSE;
      end
      SET_PULSE, RST_PULSE: begin
        pend_s_n = pend_s | req_s;
        pend_r_n = pend_r | req_r;
        if (pcnt >= PULSE_CNT_W'(PULSE_CYCLES - 1)) state_n = GAP;
      end
      GAP: begin
        pend_s_n = pend_s | req_s;
        pend_r_n = pend_r | req_r;
        state_n  = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  // State, pending flags, pulse timer and registered latch drives.
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      pend_s <= 1'b0;
      pend_r <= 1'b0;
      pcnt   <= '0;
      s_q    <= 1'b0;
      r_q    <= 1'b0;
    end else begin
      state  <= state_n;
      pend_s <= pend_s_n;
      pend_r <= pend_r_n;
      pcnt   <= (state_n != state || state == IDLE) ? '0 : pcnt + PULSE_CNT_W'(1);
      s_q    <= (state_n == SET_PULSE);
      r_q    <= (state_n == RST_PULSE);
    end
  end

  assign bus.s_out    = s_q;
  assign bus.r_out    = r_q;
  assign bus.busy     = (state != IDLE);
  assign bus.conflict = conflict_c;

endmodule

// File: tb/tb_sr_drive_ctrl.sv
// Directed bench for sr_drive_ctrl with a pulse scoreboard.
module tb_sr_drive_ctrl;

  localparam int K_S = 0, K_R = 1, K_C = 2;

  typedef struct {
    int kind;
    int start;
    int width;
  } ev_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   errors = 0;
  int   checks = 0;
  int   c0;
  ev_t  exp_q[$];
  int   act[3];
  int   st[3];

  sr_drive_if bus();

  sr_drive_ctrl #(.DEBOUNCE_CYCLES(4), .PULSE_CYCLES(2)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, exp_v, cyc);
    end
  endtask

  task automatic push(input int kind, input int start, input int width);
    ev_t e;
    e.kind = kind; e.start = start; e.width = width;
    exp_q.push_back(e);
  endtask

  task automatic finish_ev(input int kind, input int start, input int width);
    ev_t e;
    checks++;
    assert (exp_q.size() != 0) else begin
      errors++;
      $error("FAIL sb_unexpected: got kind %0d start %0d width %0d expected no pulse", kind, start, width);
    end
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      checks++;
      assert ({kind, start, width} === {e.kind, e.start, e.width}) else begin
        errors++;
        $error("FAIL sb_pulse: got kind %0d start %0d width %0d expected kind %0d start %0d width %0d",
               kind, start, width, e.kind, e.start, e.width);
      end
    end
  endtask

  // Monitor: overlap check every cycle, pulses matched against the scoreboard.
  always @(negedge clk) begin : mon
    logic [2:0] v;
    v = {bus.conflict, bus.r_out, bus.s_out};
    checks++;
    assert ((bus.s_out & bus.r_out) === 1'b0) else begin
      errors++;
      $error("FAIL overlap: got s_out&r_out=1 expected 0 (cycle %0d)", cyc);
    end
    for (int k = 0; k < 3; k++) begin
      if (v[k] === 1'b1 && act[k] == 0) begin
        act[k] = 1;
        st[k]  = cyc;
      end else if (v[k] !== 1'b1 && act[k] != 0) begin
        act[k] = 0;
        finish_ev(k, st[k], cyc - st[k]);
      end
    end
  end

  initial begin
    bus.set_btn   = 1'b0;
    bus.reset_btn = 1'b0;

    // Reset state
    tick(3);
    chk("rst_s_out", bus.s_out, 0);
    chk("rst_r_out", bus.r_out, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_conflict", bus.conflict, 0);
    rst = 1'b0;
    tick(2);

    // Clean set press: s_out 8-9, GAP 10, idle 11
    c0 = cyc;
    bus.set_btn = 1'b1;
    push(K_S, c0 + 8, 2);
    tick(7);
    chk("a_s_early", bus.s_out, 0);
    tick(1);
    chk("a_s_high", bus.s_out, 1);
    chk("a_busy", bus.busy, 1);
    tick(2);
    chk("a_gap_s", bus.s_out, 0);
    chk("a_gap_busy", bus.busy, 1);
    tick(1);
    chk("a_idle_busy", bus.busy, 0);
    chk("a_r_out", bus.r_out, 0);
    bus.set_btn = 1'b0;
    tick(10);

    // Bouncing set: toggles every cycle, never accepted
    for (int i = 0; i < 10; i++) begin
      bus.set_btn = ~bus.set_btn;
      tick(1);
    end
    bus.set_btn = 1'b0;
    tick(15);
    chk("b_busy", bus.busy, 0);
    chk("b_s_out", bus.s_out, 0);

    // Simultaneous set and reset: conflict at cycle 7 only
    c0 = cyc;
    bus.set_btn   = 1'b1;
    bus.reset_btn = 1'b1;
    push(K_C, c0 + 7, 1);
    tick(7);
    chk("c_conflict", bus.conflict, 1);
    chk("c_s_out", bus.s_out, 0);
    chk("c_r_out", bus.r_out, 0);
    chk("c_busy", bus.busy, 0);
    tick(1);
    chk("c_conflict_off", bus.conflict, 0);
    bus.set_btn   = 1'b0;
    bus.reset_btn = 1'b0;
    tick(12);

    // Reset one cycle after set: r_out queued behind the GAP
    c0 = cyc;
    bus.set_btn = 1'b1;
    push(K_S, c0 + 8, 2);
    push(K_R, c0 + 12, 2);
    tick(1);
    bus.reset_btn = 1'b1;
    tick(9);
    chk("d_gap_busy", bus.busy, 1);
    chk("d_gap_s", bus.s_out, 0);
    chk("d_gap_r", bus.r_out, 0);
    tick(1);
    chk("d_idle_busy", bus.busy, 0);
    tick(1);
    chk("d_r_high", bus.r_out, 1);
    tick(2);
    chk("d_gap2_r", bus.r_out, 0);
    chk("d_gap2_busy", bus.busy, 1);
    tick(1);
    chk("d_idle2_busy", bus.busy, 0);
    bus.set_btn   = 1'b0;
    bus.reset_btn = 1'b0;
    tick(12);

    // rst during first SET_PULSE cycle: drop immediately, pending r discarded
    c0 = cyc;
    bus.set_btn = 1'b1;
    push(K_S, c0 + 8, 1);
    tick(1);
    bus.reset_btn = 1'b1;
    tick(6);
    bus.set_btn   = 1'b0;
    bus.reset_btn = 1'b0;
    tick(1);
    chk("e_s_high", bus.s_out, 1);
    rst = 1'b1;
    tick(1);
    chk("e_s_drop", bus.s_out, 0);
    chk("e_busy", bus.busy, 0);
    chk("e_r_out", bus.r_out, 0);
    rst = 1'b0;
    tick(30);
    chk("e_quiet_busy", bus.busy, 0);

    // set held through reset release: exactly one request afterwards
    bus.set_btn = 1'b1;
    rst = 1'b1;
    tick(3);
    c0 = cyc;
    rst = 1'b0;
    push(K_S, c0 + 8, 2);
    tick(14);
    chk("f_busy", bus.busy, 0);
    bus.set_btn = 1'b0;
    tick(12);

    chk("sb_empty", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
